syncram_dp: RTL and testbench

Parametrised simple-dual-port synchronous RAM: one write port with per-lane write enables, one independent read port with a registered output and valid flag. After reset, and on request, it zero-fills the whole array with a built-in clear sequencer and signals `busy` meanwhile. It is the general storage primitive for register files, FIFOs and small buffers in the CPU datapath, replacing the single-port fixed-function RAM.

---
 rtl/syncram_pkg.sv | 15 +
 rtl/syncram_dp_if.sv | 33 +++
 rtl/syncram_dp_core.sv | 40 ++++
 rtl/syncram_dp.sv | 155 +++++++++++++++
 tb/tb_syncram_dp.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/syncram_pkg.sv
// Shared types and helpers for the syncram_dp simple-dual-port RAM.
package syncram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_READY
  } syncram_state_t;

  // Lane count; callers pair this with an elaboration-time divisibility check.
  function automatic int unsigned calc_nlanes(input int unsigned dwidth,
                                              input int unsigned lwidth);
    return dwidth / lwidth;
  endfunction

endpackage

// File: rtl/syncram_dp_if.sv
// Port bundle for syncram_dp: user write/read/clear controls and read results.
interface syncram_dp_if
  import syncram_pkg::*;
#(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned LWIDTH = 8
);

  localparam int unsigned NLANES = calc_nlanes(DWIDTH, LWIDTH);

  logic              clr;
  logic              busy;
  logic              we;
  logic [AWIDTH-1:0] waddr;
  logic [NLANES-1:0] wbe;
  logic [DWIDTH-1:0] wdata;
  logic              re;
  logic [AWIDTH-1:0] raddr;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;

  modport master (
    output clr, we, waddr, wbe, wdata, re, raddr,
    input  busy, rdata, rvalid
  );

  modport slave (
    input  clr, we, waddr, wbe, wdata, re, raddr,
    output busy, rdata, rvalid
  );

endinterface

// File: rtl/syncram_dp_core.sv
// Bare storage array: lane-masked write, registered read-first output, no reset.
module syncram_dp_core
  import syncram_pkg::*;
#(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned LWIDTH = 8
) (
  input  logic                                     clk_i,
  input  logic                                     we_i,
  input  logic [AWIDTH-1:0]                        waddr_i,
  input  logic [calc_nlanes(DWIDTH, LWIDTH)-1:0]   wbe_i,
  input  logic [DWIDTH-1:0]                        wdata_i,
  input  logic                                     re_i,
  input  logic [AWIDTH-1:0]                        raddr_i,
  output logic [DWIDTH-1:0]                        rdata_o
);

  localparam int unsigned NLANES = calc_nlanes(DWIDTH, LWIDTH);
  localparam int unsigned DEPTH  = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned l = 0; l < NLANES; l++) begin
        if (wbe_i[l]) begin
          mem_q[waddr_i][l*LWIDTH +: LWIDTH] <= wdata_i[l*LWIDTH +: LWIDTH];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/syncram_dp.sv
// Simple-dual-port synchronous RAM with clear sequencer and registered read.
// Define SYNCRAM_DP_BYPASS_EN for write-first same-address behaviour (default read-first).
module syncram_dp
  import syncram_pkg::*;
#(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned LWIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  syncram_dp_if.slave bus
);

  localparam int unsigned NLANES = calc_nlanes(DWIDTH, LWIDTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  if ((DWIDTH % LWIDTH) != 0) begin : g_lane_check
    $error("syncram_dp: DWIDTH must be a multiple of LWIDTH");
  end

  syncram_state_t    state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              loaded_q, loaded_d;

  logic              busy;
  logic              user_acc;
  logic              wr_acc;
  logic              rd_acc;

  logic              core_we;
  logic [AWIDTH-1:0] core_waddr;
  logic [NLANES-1:0] core_wbe;
  logic [DWIDTH-1:0] core_wdata;
  logic [DWIDTH-1:0] core_rdata;
  logic [DWIDTH-1:0] merged;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    user_acc = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy  = 1'b1;
        cnt_d = cnt_q + AWIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          user_acc = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_acc = user_acc & bus.we;
  assign rd_acc = user_acc & bus.re;

  // Clear sequencer owns the write port while busy.
  always_comb begin
    core_we    = busy | wr_acc;
    core_waddr = busy ? cnt_q : bus.waddr;
    core_wbe   = busy ? '1 : bus.wbe;
    core_wdata = busy ? '0 : bus.wdata;
  end

  always_comb begin
    rvalid_d = rd_acc;
    loaded_d = loaded_q | rd_acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      loaded_q <= loaded_d;
    end
  end

  syncram_dp_core #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .LWIDTH (LWIDTH)
  ) u_core (
    .clk_i   (clk),
    .we_i    (core_we),
    .waddr_i (core_waddr),
    .wbe_i   (core_wbe),
    .wdata_i (core_wdata),
    .re_i    (rd_acc),
    .raddr_i (bus.raddr),
    .rdata_o (core_rdata)
  );

`ifdef SYNCRAM_DP_BYPASS_EN
  // Core returns old contents; written lanes of a colliding write are patched in after the register.
  logic [NLANES-1:0] byp_mask_q, byp_mask_d;
  logic [DWIDTH-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_mask_d = byp_mask_q;
    byp_data_d = byp_data_q;
    if (rd_acc) begin
      byp_mask_d = (wr_acc && (bus.waddr == bus.raddr)) ? bus.wbe : '0;
      byp_data_d = bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    merged = core_rdata;
    for (int unsigned l = 0; l < NLANES; l++) begin
      if (byp_mask_q[l]) begin
        merged[l*LWIDTH +: LWIDTH] = byp_data_q[l*LWIDTH +: LWIDTH];
      end
    end
  end
`else
  always_comb begin
    merged = core_rdata;
  end
`endif

  // The core register has no reset, so rdata reads as zero until the first accepted read.
  assign bus.rdata  = loaded_q ? merged : '0;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_syncram_dp.sv
// Self-checking bench for syncram_dp: directed tests on a 16x8 instance, random traffic on a 32x64 instance.
module tb_syncram_dp;
  import syncram_pkg::*;

  localparam int unsigned DW_A = 16, AW_A = 3, DEP_A = 8;
  localparam int unsigned DW_B = 32, AW_B = 6, DEP_B = 64;
  localparam int unsigned LW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  syncram_dp_if #(.DWIDTH(DW_A), .AWIDTH(AW_A), .LWIDTH(LW)) bus_a ();
  syncram_dp_if #(.DWIDTH(DW_B), .AWIDTH(AW_B), .LWIDTH(LW)) bus_b ();

  syncram_dp #(.DWIDTH(DW_A), .AWIDTH(AW_A), .LWIDTH(LW)) dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (bus_a)
  );

  syncram_dp #(.DWIDTH(DW_B), .AWIDTH(AW_B), .LWIDTH(LW)) dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (bus_b)
  );

  int checks = 0;
  int passed = 0;

  logic [DW_A-1:0] mem_a [DEP_A];
  logic [DW_B-1:0] mem_b [DEP_B];
  int              clr_left_a = 0;
  int              clr_left_b = 0;
  logic [DW_A-1:0] exp_rd_a = '0;
  logic [DW_B-1:0] exp_rd_b = '0;
  logic            exp_rv_a = 1'b0;
  logic            exp_rv_b = 1'b0;
  logic [31:0]     sb_a [$];
  logic [31:0]     sb_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock of DUT A: drive, update model and scoreboard, check at the following negedge.
  task automatic cyc_a(input logic clr, input logic we, input logic [AW_A-1:0] waddr,
                       input logic [1:0] wbe, input logic [DW_A-1:0] wdata,
                       input logic re, input logic [AW_A-1:0] raddr);
    logic [DW_A-1:0] val;
    bus_a.clr = clr;  bus_a.we = we;  bus_a.waddr = waddr; bus_a.wbe = wbe;
    bus_a.wdata = wdata; bus_a.re = re; bus_a.raddr = raddr;
    exp_rv_a = 1'b0;
    if (clr_left_a > 0) begin
      mem_a[AW_A'(DEP_A - clr_left_a)] = '0;
      clr_left_a--;
    end else if (clr) begin
      clr_left_a = DEP_A;
    end else begin
      if (re) begin
        val = mem_a[raddr];
`ifdef SYNCRAM_DP_BYPASS_EN
        if (we && waddr == raddr)
          for (int l = 0; l < 2; l++) if (wbe[l]) val[l*LW +: LW] = wdata[l*LW +: LW];
`endif
        sb_a.push_back(32'(val));
        exp_rv_a = 1'b1;
      end
      if (we)
        for (int l = 0; l < 2; l++) if (wbe[l]) mem_a[waddr][l*LW +: LW] = wdata[l*LW +: LW];
    end
    @(posedge clk);
    @(negedge clk);
    if (bus_a.rvalid === 1'b1 && sb_a.size() > 0) exp_rd_a = DW_A'(sb_a.pop_front());
    chk("a_busy",   32'(bus_a.busy),   32'(clr_left_a > 0));
    chk("a_rvalid", 32'(bus_a.rvalid), 32'(exp_rv_a));
    chk("a_rdata",  32'(bus_a.rdata),  32'(exp_rd_a));
  endtask

  task automatic idle_a();
    cyc_a(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic reset_a();
    rst_a_n = 1'b0;
    bus_a.clr = 1'b0; bus_a.we = 1'b0; bus_a.re = 1'b0;
    #1;
    chk("a_rst_busy",   32'(bus_a.busy),   32'd1);
    chk("a_rst_rvalid", 32'(bus_a.rvalid), 32'd0);
    chk("a_rst_rdata",  32'(bus_a.rdata),  32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    clr_left_a = DEP_A;
    exp_rd_a = '0;
    sb_a.delete();
  endtask

  task automatic cyc_b(input logic clr, input logic we, input logic [AW_B-1:0] waddr,
                       input logic [3:0] wbe, input logic [DW_B-1:0] wdata,
                       input logic re, input logic [AW_B-1:0] raddr);
    logic [DW_B-1:0] val;
    bus_b.clr = clr;  bus_b.we = we;  bus_b.waddr = waddr; bus_b.wbe = wbe;
    bus_b.wdata = wdata; bus_b.re = re; bus_b.raddr = raddr;
    exp_rv_b = 1'b0;
    if (clr_left_b > 0) begin
      mem_b[AW_B'(DEP_B - clr_left_b)] = '0;
      clr_left_b--;
    end else if (clr) begin
      clr_left_b = DEP_B;
    end else begin
      if (re) begin
        val = mem_b[raddr];
`ifdef SYNCRAM_DP_BYPASS_EN
        if (we && waddr == raddr)
          for (int l = 0; l < 4; l++) if (wbe[l]) val[l*LW +: LW] = wdata[l*LW +: LW];
`endif
        sb_b.push_back(val);
        exp_rv_b = 1'b1;
      end
      if (we)
        for (int l = 0; l < 4; l++) if (wbe[l]) mem_b[waddr][l*LW +: LW] = wdata[l*LW +: LW];
    end
    @(posedge clk);
    @(negedge clk);
    if (bus_b.rvalid === 1'b1 && sb_b.size() > 0) exp_rd_b = sb_b.pop_front();
    chk("b_busy",   32'(bus_b.busy),   32'(clr_left_b > 0));
    chk("b_rvalid", 32'(bus_b.rvalid), 32'(exp_rv_b));
    chk("b_rdata",  bus_b.rdata,       exp_rd_b);
  endtask

  initial begin
    logic [AW_B-1:0] wa;
    bus_a.clr = 1'b0; bus_a.we = 1'b0; bus_a.waddr = '0; bus_a.wbe = '0;
    bus_a.wdata = '0; bus_a.re = 1'b0; bus_a.raddr = '0;
    bus_b.clr = 1'b0; bus_b.we = 1'b0; bus_b.waddr = '0; bus_b.wbe = '0;
    bus_b.wdata = '0; bus_b.re = 1'b0; bus_b.raddr = '0;
    for (int i = 0; i < DEP_A; i++) mem_a[i] = 16'hDEAD;
    for (int i = 0; i < DEP_B; i++) mem_b[i] = 32'hDEAD_BEEF;

    // Reset, busy for exactly 8 cycles, then every entry reads zero.
    @(negedge clk);
    reset_a();
    for (int i = 0; i < DEP_A; i++) idle_a();
    for (int i = 0; i < DEP_A; i++) cyc_a(1'b0, 1'b0, '0, '0, '0, 1'b1, AW_A'(i));

    // Lane-masked partial write.
    cyc_a(1'b0, 1'b1, 3'd5, 2'b11, 16'hA5C3, 1'b0, '0);
    cyc_a(1'b0, 1'b1, 3'd5, 2'b01, 16'h1234, 1'b0, '0);
    cyc_a(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd5);
    chk("a_lane_merge", 32'(bus_a.rdata), 32'h0000_A534);
    cyc_a(1'b0, 1'b1, 3'd5, 2'b00, 16'hFFFF, 1'b1, 3'd5);

    // Same-address collisions, then independent different-address traffic.
    cyc_a(1'b0, 1'b1, 3'd2, 2'b11, 16'h1111, 1'b0, '0);
    cyc_a(1'b0, 1'b1, 3'd2, 2'b11, 16'hBEEF, 1'b1, 3'd2);
`ifdef SYNCRAM_DP_BYPASS_EN
    chk("a_collide", 32'(bus_a.rdata), 32'h0000_BEEF);
`else
    chk("a_collide", 32'(bus_a.rdata), 32'h0000_1111);
`endif
    cyc_a(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd2);
    chk("a_after_collide", 32'(bus_a.rdata), 32'h0000_BEEF);
    cyc_a(1'b0, 1'b1, 3'd3, 2'b11, 16'h2222, 1'b0, '0);
    cyc_a(1'b0, 1'b1, 3'd3, 2'b10, 16'h99AA, 1'b1, 3'd3);
    cyc_a(1'b0, 1'b1, 3'd4, 2'b11, 16'h7777, 1'b1, 3'd5);
    cyc_a(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd3);
    idle_a();

    // Fill, clear with strobes attempted during busy, then read back zeros.
    for (int i = 0; i < DEP_A; i++)
      cyc_a(1'b0, 1'b1, AW_A'(i), 2'b11, 16'(16'h1000 + i * 16'h0101), 1'b0, '0);
    cyc_a(1'b1, 1'b1, 3'd1, 2'b11, 16'hFFFF, 1'b1, 3'd1);
    for (int i = 0; i < DEP_A; i++)
      cyc_a(1'b0, 1'b1, AW_A'(i), 2'b11, 16'hFFFF, 1'b1, AW_A'(i));
    for (int i = 0; i < DEP_A; i++) cyc_a(1'b0, 1'b0, '0, '0, '0, 1'b1, AW_A'(i));

    // Reset asserted at clear count 4 restarts the whole clear.
    cyc_a(1'b0, 1'b1, 3'd6, 2'b11, 16'h5555, 1'b0, '0);
    cyc_a(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd6);
    cyc_a(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) idle_a();
    reset_a();
    for (int i = 0; i < DEP_A; i++) idle_a();
    for (int i = 0; i < DEP_A; i++) cyc_a(1'b0, 1'b0, '0, '0, '0, 1'b1, AW_A'(i));

    // Random interleaved traffic on the wide instance.
    rst_b_n = 1'b1;
    @(negedge clk);
    rst_b_n = 1'b0;
    #1;
    chk("b_rst_busy",  32'(bus_b.busy),   32'd1);
    chk("b_rst_rdata", bus_b.rdata,       32'd0);
    @(negedge clk);
    rst_b_n = 1'b1;
    clr_left_b = DEP_B;
    exp_rd_b = '0;
    sb_b.delete();
    for (int i = 0; i < 10000; i++) begin
      wa = AW_B'($urandom_range(0, DEP_B - 1));
      cyc_b(($urandom_range(0, 999) == 0), 1'($urandom_range(0, 1)), wa,
            4'($urandom_range(0, 15)), 32'($urandom),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? wa : AW_B'($urandom_range(0, DEP_B - 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
